// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
package bcd_pkg;

  localparam int BIN_W  = 32;
  localparam int DIGITS = 8;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [BIN_W-1:0] MAX_VAL       = 32'd99_999_999;
  localparam logic [BCD_W-1:0] BCD_ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter with saturation at MAX_VAL.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | one add-3 + shift-left per clock, BIN_W clocks
// FINISH | publish result (or all nines on overflow), pulse done
module bin_to_bcd_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic               w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_ovf_pend <= (bin_in > MAX_VAL);
            r_cnt      <= '0;
            busy       <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Carries out of the top digit are dropped; saturation covers that case.
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= FINISH;
        end
        FINISH: begin
          bcd_out  <= r_ovf_pend ? BCD_ALL_NINES : r_bcd;
          overflow <= r_ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
